cmos_ioctl_bridge: RTL



---
 rtl/cmos_ioctl_bridge_if.sv | 24 ++
 rtl/cmos_ioctl_bridge.sv | 139 +++++++++++++
 2 files changed

// File: rtl/cmos_ioctl_bridge_if.sv
// HPS ioctl channel as seen by the NVRAM bridge.
interface cmos_ioctl_bridge_if;
  logic        ioctl_download;
  logic        ioctl_upload;
  logic [15:0] ioctl_index;
  logic [24:0] ioctl_addr;
  logic        ioctl_wr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_rd;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;

  modport master (
    output ioctl_download, ioctl_upload, ioctl_index, ioctl_addr,
           ioctl_wr, ioctl_dout, ioctl_rd,
    input  ioctl_din, ioctl_wait
  );

  modport slave (
    input  ioctl_download, ioctl_upload, ioctl_index, ioctl_addr,
           ioctl_wr, ioctl_dout, ioctl_rd,
    output ioctl_din, ioctl_wait
  );
endinterface

// File: rtl/cmos_ioctl_bridge.sv
// NVRAM save/restore bridge between the HPS ioctl channel and the
// 1024x4 CMOS RAM port B. Bytes are packed as {nib[2N+1], nib[2N]}.
module cmos_ioctl_bridge #(
  parameter int unsigned INDEX  = 4,
  parameter int unsigned NBYTES = 512
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  cmos_ioctl_bridge_if.slave       ioctl,
  output logic [9:0]               cmos_addr,
  output logic [3:0]               cmos_wdata,
  output logic                     cmos_we,
  input  logic [3:0]               cmos_rdata,
  input  logic                     cpu_cmos_we,
  output logic                     cmos_dirty
);

  localparam logic [24:0] NB  = 25'(NBYTES);
  localparam logic [7:0]  IDX = 8'(INDEX);

  typedef enum logic [2:0] {IDLE, WR_LO, WR_HI, RD_LO, RD_WAIT, RD_HI} state_t;

  state_t      state_q, state_d;
  logic [8:0]  a_q, a_d;
  logic [3:0]  hi_q, hi_d;
  logic [3:0]  lo_q, lo_d;
  logic        last_q, last_d;
  logic [7:0]  din_q, din_d;
  logic [9:0]  addr_q, addr_d;
  logic [3:0]  wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        dirty_q, dirty_d;

  logic        sel, wr_v, rd_v, in_range, is_last;
  logic        unused_index_hi;

  assign sel      = (ioctl.ioctl_index[7:0] == IDX);
  assign wr_v     = sel && ioctl.ioctl_download && ioctl.ioctl_wr;
  assign rd_v     = sel && ioctl.ioctl_upload && ioctl.ioctl_rd;
  assign in_range = (ioctl.ioctl_addr < NB);
  assign is_last  = (ioctl.ioctl_addr == NB - 25'd1);
  assign unused_index_hi = &{1'b0, ioctl.ioctl_index[15:8]};

  assign ioctl.ioctl_din  = din_q;
  assign ioctl.ioctl_wait = (state_q != IDLE);
  assign cmos_addr        = addr_q;
  assign cmos_wdata       = wdata_q;
  assign cmos_we          = we_q;
  assign cmos_dirty       = dirty_q;

  // Port B outputs are registered and computed for the state being entered,
  // so cmos_addr naturally holds its last value while idle.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    last_d  = last_q;
    din_d   = din_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    dirty_d = dirty_q;

    case (state_q)
      IDLE: begin
        if (wr_v) begin
          if (in_range) begin
            state_d = WR_LO;
            a_d     = ioctl.ioctl_addr[8:0];
            hi_d    = ioctl.ioctl_dout[7:4];
            we_d    = 1'b1;
            addr_d  = {ioctl.ioctl_addr[8:0], 1'b0};
            wdata_d = ioctl.ioctl_dout[3:0];
          end
        end else if (rd_v) begin
          if (in_range) begin
            state_d = RD_LO;
            a_d     = ioctl.ioctl_addr[8:0];
            last_d  = is_last;
            addr_d  = {ioctl.ioctl_addr[8:0], 1'b0};
          end else begin
            din_d = 8'hFF;
          end
        end
      end
      WR_LO: begin
        state_d = WR_HI;
        we_d    = 1'b1;
        addr_d  = {a_q, 1'b1};
        wdata_d = hi_q;
      end
      WR_HI: state_d = IDLE;
      RD_LO: begin
        state_d = RD_WAIT;
        addr_d  = {a_q, 1'b1};
      end
      RD_WAIT: begin
        state_d = RD_HI;
        lo_d    = cmos_rdata;
      end
      RD_HI: begin
        state_d = IDLE;
        din_d   = {cmos_rdata, lo_q};
        if (last_q) dirty_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    if (cpu_cmos_we) dirty_d = 1'b1;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      last_q  <= 1'b0;
      din_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      dirty_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      last_q  <= last_d;
      din_q   <= din_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      dirty_q <= dirty_d;
    end
  end

endmodule
